// File: rtl/mem_wb_pkg.sv
// mem_wb_pkg: shared pipeline defines for the MEM/WB stage register.
// Supplies the register bus widths, the stall vector bit positions,
// the Stop/NoStop, WriteEnable/WriteDisable and RstEnable levels, the
// WB-stage state record, its bubble value and the update-action decoder.
package mem_wb_pkg;

  localparam int REG_BUS_W  = 32;
  localparam int REG_ADDR_W = 5;
  localparam int STALL_W    = 6;
  localparam int STALL_MEM  = 4;
  localparam int STALL_WB   = 5;
  localparam int CNT_W      = 32;

  localparam logic STOP          = 1'b1;
  localparam logic NO_STOP       = 1'b0;
  localparam logic WRITE_ENABLE  = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;
  localparam logic RST_ENABLE    = 1'b1;

  typedef logic [REG_BUS_W-1:0]  reg_bus_t;
  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [STALL_W-1:0]    stall_t;

  localparam reg_bus_t  ZERO_WORD    = '0;
  localparam reg_addr_t NOP_REG_ADDR = '0;

  // What the stage register does on the coming edge (reset handled separately).
  typedef enum logic [1:0] {
    UPD_HOLD,
    UPD_BUBBLE,
    UPD_CAPTURE
  } upd_e;

  typedef struct packed {
    reg_addr_t wd;
    logic      wreg;
    reg_bus_t  wdata;
    logic      whilo;
    reg_bus_t  hi;
    reg_bus_t  lo;
  } wb_state_t;

  localparam wb_state_t WB_BUBBLE = '{
    wd:    NOP_REG_ADDR,
    wreg:  WRITE_DISABLE,
    wdata: ZERO_WORD,
    whilo: WRITE_DISABLE,
    hi:    ZERO_WORD,
    lo:    ZERO_WORD
  };

  // Flush beats everything; a stalled MEM feeding a running WB must insert
  // a bubble so the stalled instruction is not written back twice.
  function automatic upd_e select_update(input logic flush, input stall_t stall);
    if (flush)
      return UPD_BUBBLE;
    else if (stall[STALL_MEM] == STOP && stall[STALL_WB] == NO_STOP)
      return UPD_BUBBLE;
    else if (stall[STALL_MEM] == NO_STOP)
      return UPD_CAPTURE;
    else
      return UPD_HOLD;
  endfunction

endpackage

// File: rtl/mem_wb_if.sv
// mem_wb_if: MEM-side inputs and WB-side regfile / HI-LO write ports of
// the MEM/WB stage register.
//   slave  : the stage register (reads mem_*, stall, flush; drives wb_*)
//   master : the pipeline side (drives mem_*, stall, flush; reads wb_*)
interface mem_wb_if;
  import mem_wb_pkg::*;

  reg_addr_t mem_wd;
  logic      mem_wreg;
  reg_bus_t  mem_wdata;
  logic      mem_whilo;
  reg_bus_t  mem_hi;
  reg_bus_t  mem_lo;
  logic      mem_valid;
  stall_t    stall;
  logic      flush;

  reg_addr_t wb_wd;
  logic      wb_wreg;
  reg_bus_t  wb_wdata;
  logic      wb_whilo;
  reg_bus_t  wb_hi;
  reg_bus_t  wb_lo;

  modport slave (
    input  mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo,
    input  mem_valid, stall, flush,
    output wb_wd, wb_wreg, wb_wdata, wb_whilo, wb_hi, wb_lo
  );

  modport master (
    output mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo,
    output mem_valid, stall, flush,
    input  wb_wd, wb_wreg, wb_wdata, wb_whilo, wb_hi, wb_lo
  );

endinterface

// File: rtl/mem_wb_retire_counter.sv
// retire_counter: free-running retired-instruction counter.
// Ports: clk, rst (sync, active-high), inc (count one this edge),
//        cnt (current count, wraps at all-ones).
module retire_counter
  import mem_wb_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Natural modulo-2^32 add gives the required wrap without saturation.
  always_comb begin
    cnt_d = cnt_q;
    if (inc)
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/mem_wb.sv
// mem_wb: MEM/WB pipeline stage register.
// Ports: clk, rst (sync, active-high), bus (mem_wb_if.slave: mem_* in,
//        stall/flush in, wb_* regfile and HI/LO write ports out),
//        retire_cnt (only when WB_RETIRE_CNT_EN is defined).
// All outputs come straight from flops, so there is no input-to-output
// combinational path and the regfile sees stable write data all cycle.
// Optional feature macro: WB_RETIRE_CNT_EN adds the retire counter.
module mem_wb
  import mem_wb_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  mem_wb_if.slave   bus
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [CNT_W-1:0] retire_cnt
`endif
);

  wb_state_t wb_q;
  wb_state_t wb_d;
  upd_e      upd;

  always_comb begin
    upd  = select_update(bus.flush, bus.stall);
    wb_d = wb_q;
    case (upd)
      UPD_BUBBLE: wb_d = WB_BUBBLE;
      UPD_CAPTURE: begin
        wb_d.wd    = bus.mem_wd;
        // Register 0 is hardwired; never let a write to it reach the regfile.
        wb_d.wreg  = (bus.mem_wd == NOP_REG_ADDR) ? WRITE_DISABLE : bus.mem_wreg;
        wb_d.wdata = bus.mem_wdata;
        wb_d.whilo = bus.mem_whilo;
        wb_d.hi    = bus.mem_hi;
        wb_d.lo    = bus.mem_lo;
      end
      default: wb_d = wb_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE)
      wb_q <= WB_BUBBLE;
    else
      wb_q <= wb_d;
  end

  assign bus.wb_wd    = wb_q.wd;
  assign bus.wb_wreg  = wb_q.wreg;
  assign bus.wb_wdata = wb_q.wdata;
  assign bus.wb_whilo = wb_q.whilo;
  assign bus.wb_hi    = wb_q.hi;
  assign bus.wb_lo    = wb_q.lo;

`ifdef WB_RETIRE_CNT_EN
  logic retire_inc;

  // Captures only happen with flush low, so this already excludes flushes.
  assign retire_inc = (upd == UPD_CAPTURE) && bus.mem_valid;

  retire_counter u_retire (
    .clk (clk),
    .rst (rst),
    .inc (retire_inc),
    .cnt (retire_cnt)
  );
`endif

endmodule

// File: tb/tb_mem_wb.sv
// tb_mem_wb: directed self-checking bench for the MEM/WB stage register.
// Inputs are driven on the falling edge, outputs checked on the next
// falling edge after one rising edge. A small shadow regfile (with no
// hardwired zero) observes the write port. With WB_RETIRE_CNT_EN the
// retire counter is also exercised, including the all-ones wrap.
module tb_mem_wb;
  import mem_wb_pkg::*;

  logic clk;
  logic rst;
  int   compared;
  int   mismatched;

  reg_bus_t shadow_rf [32];

  mem_wb_if bus ();

`ifdef WB_RETIRE_CNT_EN
  logic [CNT_W-1:0] retire_cnt;
`endif

  mem_wb dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef WB_RETIRE_CNT_EN
    ,
    .retire_cnt (retire_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shadow regfile: writes any address, so reg 0 only stays 0 if the DUT
  // keeps its write enable low.
  always @(posedge clk) begin
    if (bus.wb_wreg)
      shadow_rf[bus.wb_wd] <= bus.wb_wdata;
  end

  task automatic applyStimulus(
    input logic      r,
    input logic      fl,
    input stall_t    st,
    input logic      valid,
    input reg_addr_t wd,
    input logic      wreg,
    input reg_bus_t  wdata,
    input logic      whilo,
    input reg_bus_t  hi,
    input reg_bus_t  lo
  );
    rst           = r;
    bus.flush     = fl;
    bus.stall     = st;
    bus.mem_valid = valid;
    bus.mem_wd    = wd;
    bus.mem_wreg  = wreg;
    bus.mem_wdata = wdata;
    bus.mem_whilo = whilo;
    bus.mem_hi    = hi;
    bus.mem_lo    = lo;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(
    input string     tag,
    input reg_addr_t wd,
    input logic      wreg,
    input reg_bus_t  wdata,
    input logic      whilo,
    input reg_bus_t  hi,
    input reg_bus_t  lo
  );
    wb_state_t obs;
    wb_state_t exp;
    obs = '{wd: bus.wb_wd, wreg: bus.wb_wreg, wdata: bus.wb_wdata,
            whilo: bus.wb_whilo, hi: bus.wb_hi, lo: bus.wb_lo};
    exp = '{wd: wd, wreg: wreg, wdata: wdata, whilo: whilo, hi: hi, lo: lo};
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed wd=%h wreg=%b wdata=%h whilo=%b hi=%h lo=%h expected wd=%h wreg=%b wdata=%h whilo=%b hi=%h lo=%h",
             tag, obs.wd, obs.wreg, obs.wdata, obs.whilo, obs.hi, obs.lo,
             exp.wd, exp.wreg, exp.wdata, exp.whilo, exp.hi, exp.lo);
    end
  endtask

  task automatic checkRegfile(input string tag, input int idx, input reg_bus_t expected);
    compared++;
    assert (shadow_rf[idx] === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, shadow_rf[idx], expected);
    end
  endtask

`ifdef WB_RETIRE_CNT_EN
  task automatic checkCount(input string tag, input logic [CNT_W-1:0] expected);
    compared++;
    assert (retire_cnt === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, retire_cnt, expected);
    end
  endtask
`endif

  initial begin
    compared   = 0;
    mismatched = 0;
    for (int i = 0; i < 32; i++) shadow_rf[i] = '0;

    // Reset overrides flush, hold and live MEM data.
    applyStimulus(1, 1, 6'b110000, 1, 5'd7, 1, 32'hAAAA5555, 1, 32'h1, 32'h2);
    checkOutput("reset", 0, 0, 0, 0, 0, 0);
`ifdef WB_RETIRE_CNT_EN
    checkCount("reset_cnt", 32'h0);
`endif

    // Plain capture.
    applyStimulus(0, 0, 6'b000000, 1, 5'd5, 1, 32'hDEADBEEF, 0, 32'h0, 32'h0);
    checkOutput("capture_basic", 5, 1, 32'hDEADBEEF, 0, 0, 0);

    // Regfile and HI/LO written in the same cycle.
    applyStimulus(0, 0, 6'b000000, 1, 5'd9, 1, 32'h12345678, 1, 32'h11111111, 32'h22222222);
    checkOutput("capture_both", 9, 1, 32'h12345678, 1, 32'h11111111, 32'h22222222);
    checkRegfile("rf_reg5", 5, 32'hDEADBEEF);

    // MEM stalled, WB running: bubble.
    applyStimulus(0, 0, 6'b010000, 1, 5'd3, 1, 32'h0000CAFE, 1, 32'h3, 32'h4);
    checkOutput("stall_bubble", 0, 0, 0, 0, 0, 0);

    // Capture a known value, then hold it for two cycles while MEM changes.
    applyStimulus(0, 0, 6'b000000, 1, 5'd3, 1, 32'h0000CAFE, 1, 32'hA1, 32'hB2);
    checkOutput("capture_prehold", 3, 1, 32'h0000CAFE, 1, 32'hA1, 32'hB2);
    applyStimulus(0, 0, 6'b110000, 1, 5'd8, 0, 32'h99999999, 0, 32'h5, 32'h6);
    checkOutput("hold_1", 3, 1, 32'h0000CAFE, 1, 32'hA1, 32'hB2);
    applyStimulus(0, 0, 6'b110000, 1, 5'd10, 1, 32'h77777777, 1, 32'h7, 32'h8);
    checkOutput("hold_2", 3, 1, 32'h0000CAFE, 1, 32'hA1, 32'hB2);

    // Flush beats hold, then flush beats capture.
    applyStimulus(0, 1, 6'b110000, 1, 5'd4, 1, 32'h44444444, 1, 32'h9, 32'hA);
    checkOutput("flush_over_hold", 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 6'b000000, 1, 5'd4, 1, 32'h44444444, 1, 32'h9, 32'hA);
    checkOutput("flush_over_capture", 0, 0, 0, 0, 0, 0);

    // Write to register 0 is suppressed but data still captured.
    applyStimulus(0, 0, 6'b000000, 1, 5'd0, 1, 32'h00000001, 0, 32'h0, 32'h0);
    checkOutput("reg0_capture", 0, 0, 32'h00000001, 0, 0, 0);
    applyStimulus(0, 0, 6'b000000, 0, 5'd2, 1, 32'h00002222, 0, 32'h0, 32'h0);
    checkOutput("capture_invalid", 2, 1, 32'h00002222, 0, 0, 0);
    checkRegfile("rf_reg0", 0, 32'h0);

    // Reset in the middle of a hold discards the held instruction.
    applyStimulus(0, 0, 6'b000000, 1, 5'd4, 1, 32'h00000077, 0, 32'h0, 32'h0);
    checkOutput("capture_prereset", 4, 1, 32'h00000077, 0, 0, 0);
    applyStimulus(0, 0, 6'b110000, 1, 5'd1, 0, 32'h0, 0, 32'h0, 32'h0);
    checkOutput("hold_prereset", 4, 1, 32'h00000077, 0, 0, 0);
    applyStimulus(1, 0, 6'b110000, 1, 5'd1, 0, 32'h0, 0, 32'h0, 32'h0);
    checkOutput("reset_mid_hold", 0, 0, 0, 0, 0, 0);
`ifdef WB_RETIRE_CNT_EN
    checkCount("reset_mid_hold_cnt", 32'h0);
`endif
    applyStimulus(0, 0, 6'b000000, 1, 5'd6, 1, 32'h00000088, 0, 32'h0, 32'h0);
    checkOutput("capture_after_reset", 6, 1, 32'h00000088, 0, 0, 0);

`ifdef WB_RETIRE_CNT_EN
    // Preload near the wrap point, then count through it.
    force dut.u_retire.cnt_q = 32'hFFFFFFFE;
    #1;
    release dut.u_retire.cnt_q;
    checkCount("preload", 32'hFFFFFFFE);
    applyStimulus(0, 0, 6'b000000, 1, 5'd1, 1, 32'h1, 0, 32'h0, 32'h0);
    checkCount("cnt_ffffffff", 32'hFFFFFFFF);
    applyStimulus(0, 0, 6'b000000, 1, 5'd1, 1, 32'h2, 0, 32'h0, 32'h0);
    checkCount("cnt_wrap", 32'h0);
    applyStimulus(0, 0, 6'b000000, 1, 5'd1, 1, 32'h3, 0, 32'h0, 32'h0);
    checkCount("cnt_one", 32'h1);
    applyStimulus(0, 0, 6'b010000, 1, 5'd1, 1, 32'h4, 0, 32'h0, 32'h0);
    checkCount("cnt_bubble", 32'h1);
    applyStimulus(0, 0, 6'b110000, 1, 5'd1, 1, 32'h5, 0, 32'h0, 32'h0);
    checkCount("cnt_hold", 32'h1);
    applyStimulus(0, 1, 6'b000000, 1, 5'd1, 1, 32'h6, 0, 32'h0, 32'h0);
    checkCount("cnt_flush", 32'h1);
    applyStimulus(0, 0, 6'b000000, 0, 5'd1, 1, 32'h7, 0, 32'h0, 32'h0);
    checkCount("cnt_invalid", 32'h1);
    applyStimulus(0, 0, 6'b000000, 1, 5'd1, 1, 32'h8, 0, 32'h0, 32'h0);
    checkCount("cnt_two", 32'h2);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mem_wb.md
MEM_WB -- requirements
Module: mem_wb

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 rst  in  1  synchronous active-high reset (`RstEnable).
REQ-004 mem_wd  in  `RegAddrBus  destination register address from MEM.
REQ-005 mem_wreg  in  1  register write enable from MEM.
REQ-006 mem_wdata  in  `RegBus  write data from MEM.
REQ-007 mem_whilo  in  1  HI/LO write enable from MEM.
REQ-008 mem_hi, mem_lo  in  `RegBus each  HI/LO write data from MEM.
REQ-009 mem_valid  in  1  MEM holds a real (non-bubble) instruction.
REQ-010 stall  in  6  pipeline stall vector; bit 4 = MEM, bit 5 = WB.
REQ-011 flush  in  1  exception flush; discards the MEM-stage instruction.
REQ-012 wb_wd, wb_wreg, wb_wdata  out  `RegAddrBus/1/`RegBus  regfile write port (waddr/we/wdata).
REQ-013 wb_whilo, wb_hi, wb_lo  out  1/`RegBus/`RegBus  HI/LO register write port.
REQ-014 retire_cnt  out  32  retired-instruction count (present only with WB_RETIRE_CNT_EN).

Function
REQ-015 All outputs SHALL be registered; MEM-to-WB latency is exactly one clk cycle.
REQ-016 Update priority at each rising edge SHALL be: rst, then flush, then bubble, then capture, then hold.
REQ-017 flush=1 (rst=0) SHALL load a bubble: all outputs zero and both write enables disabled.
REQ-018 stall[4]=Stop with stall[5]=NoStop SHALL load a bubble, so the stalled MEM instruction is never written twice.
REQ-019 stall[4]=NoStop SHALL capture all mem_* inputs into the corresponding wb_* outputs.
REQ-020 stall[4]=Stop with stall[5]=Stop SHALL hold every output unchanged.
REQ-021 Capture with mem_wd=0 SHALL force wb_wreg to WriteDisable; wb_wdata is still captured.
REQ-022 Outputs SHALL stay stable for the whole cycle, because the regfile forwards wdata combinationally to same-cycle reads.
REQ-023 wb_whilo and wb_wreg SHALL be independent; both may be asserted in the same cycle.
REQ-024 No combinational path SHALL exist from any input to any output.

Reset
REQ-025 rst=1 at a rising edge SHALL drive all wb_* outputs to zero/disabled and retire_cnt to 0, overriding flush and stall.
REQ-026 Reset mid-hold SHALL discard the held instruction; the first capture after reset SHALL occur on the first edge with rst=0 and stall[4]=NoStop.

Configuration
REQ-027 With WB_RETIRE_CNT_EN defined, the block SHALL provide a 32-bit retire_cnt that increments by 1 on each capture where mem_valid=1 and flush=0.
REQ-028 retire_cnt SHALL NOT change on a bubble, a hold, a flush, or a capture with mem_valid=0.
REQ-029 retire_cnt SHALL wrap from 32'hFFFFFFFF to 0 without saturating.
REQ-030 With WB_RETIRE_CNT_EN undefined, the retire_cnt port and its counter SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-031 The stall bit indices, Stop/NoStop, `RegBus, `RegAddrBus, `ZeroWord, `WriteEnable/`WriteDisable and `RstEnable SHALL come from the shared defines package; the block SHALL contain no local literals for them.
REQ-032 The retire counter SHALL be a sub-module, retire_counter, instantiated only under WB_RETIRE_CNT_EN.

Verification
REQ-033 Scenario 1: stall=0; mem_wd=5, mem_wreg=1, mem_wdata=32'hDEADBEEF -> one edge later wb_wd=5, wb_wreg=1, wb_wdata=32'hDEADBEEF.
REQ-034 Scenario 2: stall=6'b010000 with a valid write to reg 3 -> wb_wreg=0, wb_wdata=0 next cycle; with stall=6'b110000 the outputs hold their prior values.
REQ-035 Scenario 3: flush=1 with stall=6'b110000 and mem_wreg=1 -> wb_wreg=0 next cycle (flush beats hold).
REQ-036 Scenario 4: mem_wd=0, mem_wreg=1, mem_wdata=32'h1 -> wb_wreg=0; in a regfile co-simulation, reg 0 still reads 0.
REQ-037 Scenario 5: rst=1 pulsed during a hold with wb_wreg=1 -> all outputs 0 after the edge; rst=0 with stall=0 -> capture resumes on the next edge.
REQ-038 Scenario 6 (WB_RETIRE_CNT_EN): preload retire_cnt to 32'hFFFFFFFE, then three valid captures -> FFFFFFFF, 0, 1; bubble, hold and flush cycles leave the count unchanged.
